last_register_writer: RTL and testbench
=======================================

LAST_REGISTER_WRITER -- requirements
Module: last_register_writer

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, meaning the goal-row width in slots.
REQ-002 SHALL have port CLOCK_50  in  1  system clock, rising edge; one clock only.
REQ-003 SHALL have port RESET_InHigh  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port frogRow_InBUS  in  DATAWIDTH  frog position in the lane below the goal row, one-hot; zero means no frog.
REQ-005 SHALL have port arrive_In  in  1  single-cycle strobe: the frog enters the goal row this cycle.
REQ-006 SHALL have port clear_In  in  1  starts a new level; empties the goal row.
REQ-007 SHALL have port ack_In  in  1  controller acknowledges levelDone_Out.
REQ-008 SHALL have port dataLastRegister_OutBUS  out  DATAWIDTH  registered goal-row occupancy.
REQ-009 SHALL have port dataOR_OutBUS  out  DATAWIDTH  combinational dataLastRegister_OutBUS OR frogRow_InBUS, zero latency.
REQ-010 SHALL have port count_OutBUS  out  clog2(DATAWIDTH+1)  number of occupied slots.
REQ-011 SHALL have port levelDone_Out  out  1  goal row full, held until acknowledged.
REQ-012 SHALL have port collision_Out  out  1  one-cycle pulse: arrival on an occupied slot.
REQ-013 SHALL have port state_OutBUS  out  2  current FSM state encoding.

Function
REQ-014 SHALL have FSM states: IDLE=00, TRACK=01, COMMIT=10, DONE=11.
REQ-015 SHALL, in IDLE, ignore arrive_In and ack_In; clear_In moves it to TRACK.
REQ-016 SHALL, in TRACK with arrive_In=1 and frogRow_InBUS nonzero, latch the lowest-index set bit of frogRow_InBUS into a pending register and enter COMMIT next cycle.
REQ-017 SHALL, in TRACK with arrive_In=1 and frogRow_InBUS zero, ignore the strobe and remain in TRACK.
REQ-018 SHALL, in COMMIT, OR the pending bit into the goal register, increment count by 1 only if the bit was previously clear, and update both at the clock edge that leaves COMMIT (one-cycle latency from entering COMMIT).
REQ-019 SHALL leave COMMIT for DONE if the updated register is all ones, else for TRACK.
REQ-020 SHALL ignore arrive_In asserted while in COMMIT (strobe dropped, no queuing).
REQ-021 SHALL hold levelDone_Out=1 throughout DONE; ack_In in DONE moves to IDLE with the register and count retained.
REQ-022 SHALL saturate count at DATAWIDTH; it never wraps.
REQ-023 SHALL, on clear_In in any state, zero the register, count and pending register and enter TRACK next cycle; clear_In has priority over arrive_In and ack_In in the same cycle.
REQ-024 SHALL drive dataOR_OutBUS purely combinationally in every state, including IDLE and DONE.

Reset
REQ-025 SHALL, on RESET_InHigh=1 at a clock edge, enter IDLE with dataLastRegister_OutBUS=0, count_OutBUS=0, pending=0, levelDone_Out=0, collision_Out=0.
REQ-026 SHALL give reset priority over clear_In; reset mid-COMMIT discards the pending bit.

Configuration
REQ-027 SHALL provide macro LAST_REGISTER_WRITER_COLLISION_EN.
REQ-028 SHALL, with the macro defined, pulse collision_Out for exactly the cycle after COMMIT when the pending bit was already set; register and count stay unchanged.
REQ-029 SHALL, without the macro, tie collision_Out to 0; re-arrival on an occupied slot is a silent no-op.

Structure
REQ-030 SHALL place in a shared package: FSM state encodings, DATAWIDTH default, the all-ones goal constant, and the count width.
REQ-031 SHALL use one sub-module, last_register_lsb_select: combinational lowest-set-bit isolator, DATAWIDTH in / DATAWIDTH out.

Verification
REQ-032 SHALL cover: reset, clear, then arrive with frogRow=8'b00000100 -> after 2 cycles register=00000100, count=1, state TRACK.
REQ-033 SHALL cover: arrivals at slots 0..7 sequentially -> after the eighth commit register=8'hFF, count=8, levelDone_Out=1; ack -> IDLE with register still 8'hFF.
REQ-034 SHALL cover: frogRow=8'b01010000 with arrive -> only bit 4 committed, count +1.
REQ-035 SHALL cover, with the macro: second arrival on bit 2 -> collision_Out high for 1 cycle, count unchanged; without the macro -> collision_Out stays 0.
REQ-036 SHALL cover: clear_In and arrive_In in the same TRACK cycle -> register=0, count=0, no commit; arrive during COMMIT -> dropped.
REQ-037 SHALL cover: RESET_InHigh asserted in COMMIT -> next cycle IDLE, register=0, pending discarded.

Source files
------------

// File: rtl/last_register_writer_pkg.sv
// Shared definitions for the goal-row register writer: state encodings,
// default row width, the all-ones goal constant and the count width.
package last_register_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_TRACK  = 2'b01,
        ST_COMMIT = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    localparam int DATAWIDTH_DEF = 8;

    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int COUNT_W_DEF = count_width(DATAWIDTH_DEF);

    localparam logic [DATAWIDTH_DEF-1:0] GOAL_FULL_DEF = '1;

endpackage

// File: rtl/last_register_writer_lsb_select.sv
// Combinational isolator: keeps only the lowest-index set bit of its input.
module last_register_lsb_select #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] vec_in,
    output logic [DATAWIDTH-1:0] vec_out
);

    // Two's-complement trick: x & -x leaves the least significant one.
    assign vec_out = vec_in & (~vec_in + {{(DATAWIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/last_register_writer.sv
// Goal-row occupancy tracker for the frog game: commits arriving frogs into a
// register, counts occupied slots and flags a full row. Optional collision
// pulse enabled by defining LAST_REGISTER_WRITER_COLLISION_EN.
module last_register_writer
    import last_register_writer_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    localparam int CW = count_width(DATAWIDTH)
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_InHigh,
    input  logic [DATAWIDTH-1:0] frogRow_InBUS,
    input  logic                 arrive_In,
    input  logic                 clear_In,
    input  logic                 ack_In,
    output logic [DATAWIDTH-1:0] dataLastRegister_OutBUS,
    output logic [DATAWIDTH-1:0] dataOR_OutBUS,
    output logic [CW-1:0]        count_OutBUS,
    output logic                 levelDone_Out,
    output logic                 collision_Out,
    output logic [1:0]           state_OutBUS
);

    localparam logic [DATAWIDTH-1:0] GOAL_FULL = {DATAWIDTH{1'b1}};
    localparam logic [CW-1:0]        COUNT_MAX = CW'(DATAWIDTH);

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] goal_q, goal_d;
    logic [DATAWIDTH-1:0] pend_q, pend_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DATAWIDTH-1:0] frog_lsb;
    logic [DATAWIDTH-1:0] goal_merged;
    logic                 already_set;

    last_register_lsb_select #(
        .DATAWIDTH(DATAWIDTH)
    ) u_lsb_select (
        .vec_in (frogRow_InBUS),
        .vec_out(frog_lsb)
    );

    assign goal_merged = goal_q | pend_q;
    assign already_set = (goal_q & pend_q) != '0;

    always_comb begin
        state_d = state_q;
        goal_d  = goal_q;
        pend_d  = pend_q;
        count_d = count_q;
        if (clear_In) begin
            state_d = ST_TRACK;
            goal_d  = '0;
            pend_d  = '0;
            count_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_TRACK: begin
                    if (arrive_In && (frogRow_InBUS != '0)) begin
                        pend_d  = frog_lsb;
                        state_d = ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    goal_d = goal_merged;
                    pend_d = '0;
                    if (!already_set && (count_q != COUNT_MAX))
                        count_d = count_q + 1'b1;
                    state_d = (goal_merged == GOAL_FULL) ? ST_DONE : ST_TRACK;
                end
                ST_DONE: begin
                    if (ack_In)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET_InHigh) begin
            state_q <= ST_IDLE;
            goal_q  <= '0;
            pend_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            goal_q  <= goal_d;
            pend_q  <= pend_d;
            count_q <= count_d;
        end
    end

`ifdef LAST_REGISTER_WRITER_COLLISION_EN
    logic collision_q, collision_d;

    // Pulse lands in the cycle after COMMIT; a clear in that cycle wins.
    always_comb begin
        collision_d = 1'b0;
        if (!clear_In && (state_q == ST_COMMIT) && already_set)
            collision_d = 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET_InHigh)
            collision_q <= 1'b0;
        else
            collision_q <= collision_d;
    end

    assign collision_Out = collision_q;
`else
    assign collision_Out = 1'b0;
`endif

    assign dataLastRegister_OutBUS = goal_q;
    assign dataOR_OutBUS           = goal_q | frogRow_InBUS;
    assign count_OutBUS            = count_q;
    assign levelDone_Out           = (state_q == ST_DONE);
    assign state_OutBUS            = state_q;

endmodule

// File: tb/tb_last_register_writer.sv
// Scoreboard bench for last_register_writer: directed scenarios followed by
// random stimulus, compared against a slot-level reference model.
module tb_last_register_writer;

    localparam int DW = 8;
    localparam int CW = $clog2(DW + 1);

`ifdef LAST_REGISTER_WRITER_COLLISION_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] goal;
        logic [DW-1:0] orv;
        logic [CW-1:0] cnt;
        logic [1:0]    st;
        logic          done;
        logic          col;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] frog;
    logic          arrive, clear, ack;
    logic [DW-1:0] goal_o, or_o;
    logic [CW-1:0] cnt_o;
    logic          done_o, col_o;
    logic [1:0]    st_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    // Reference model: phase name, slot occupancy and pending slot index.
    int      m_phase = 0;  // 0 idle, 1 track, 2 commit, 3 done
    bit      m_slot[DW];
    int      m_pend = -1;
    bit      m_col = 0;

    last_register_writer #(.DATAWIDTH(DW)) dut (
        .CLOCK_50               (clk),
        .RESET_InHigh           (rst),
        .frogRow_InBUS          (frog),
        .arrive_In              (arrive),
        .clear_In               (clear),
        .ack_In                 (ack),
        .dataLastRegister_OutBUS(goal_o),
        .dataOR_OutBUS          (or_o),
        .count_OutBUS           (cnt_o),
        .levelDone_Out          (done_o),
        .collision_Out          (col_o),
        .state_OutBUS           (st_o)
    );

    always #10 clk = ~clk;

    function automatic logic [DW-1:0] slots_vec();
        logic [DW-1:0] v = '0;
        for (int i = 0; i < DW; i++) v[i] = m_slot[i];
        return v;
    endfunction

    function automatic int slots_used();
        int n = 0;
        for (int i = 0; i < DW; i++) n += m_slot[i];
        return n;
    endfunction

    task automatic model_step(input bit r, input bit c, input bit a,
                              input bit k, input logic [DW-1:0] f);
        if (r || c) begin
            m_phase = r ? 0 : 1;
            for (int i = 0; i < DW; i++) m_slot[i] = 0;
            m_pend = -1;
            m_col  = 0;
        end else begin
            m_col = 0;
            case (m_phase)
                1: if (a && f != '0) begin
                    for (int i = DW - 1; i >= 0; i--) if (f[i]) m_pend = i;
                    m_phase = 2;
                end
                2: begin
                    if (m_slot[m_pend]) m_col = COLL_EN;
                    else m_slot[m_pend] = 1;
                    m_pend  = -1;
                    m_phase = (slots_used() == DW) ? 3 : 1;
                end
                3: if (k) m_phase = 0;
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input bit r, input bit c, input bit a, input bit k,
                       input logic [DW-1:0] f);
        exp_t e;
        @(negedge clk);
        rst = r; clear = c; arrive = a; ack = k; frog = f;
        model_step(r, c, a, k, f);
        e.goal = slots_vec();
        e.orv  = slots_vec() | f;
        e.cnt  = CW'(slots_used());
        e.st   = 2'(m_phase);
        e.done = (m_phase == 3);
        e.col  = m_col;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, '0);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: every edge that has a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("register", 32'(goal_o), 32'(e.goal));
                chk("data_or",  32'(or_o),   32'(e.orv));
                chk("count",    32'(cnt_o),  32'(e.cnt));
                chk("state",    32'(st_o),   32'(e.st));
                chk("level_done", 32'(done_o), 32'(e.done));
                chk("collision",  32'(col_o),  32'(e.col));
            end
        end
    end

    initial begin
        logic [DW-1:0] f;
        int wait_cycles;
        rst = 1'b1; clear = 1'b0; arrive = 1'b0; ack = 1'b0; frog = '0;

        cyc(1, 0, 0, 0, '0);
        cyc(0, 1, 0, 0, '0);
        cyc(0, 0, 1, 0, 8'b0000_0100);
        idle(); idle();
        // Re-arrival on slot 2
        cyc(0, 0, 1, 0, 8'b0000_0100);
        idle(); idle();
        // Two frogs visible: only bit 4 commits
        cyc(0, 0, 1, 0, 8'b0101_0000);
        idle();
        // Clear and arrive in the same TRACK cycle
        cyc(0, 1, 1, 0, 8'b0000_0001);
        idle();
        // Arrival during COMMIT is dropped
        cyc(0, 0, 1, 0, 8'b0000_0010);
        cyc(0, 0, 1, 0, 8'b1000_0000);
        idle(); idle();
        // Fill the row slot by slot
        cyc(0, 1, 0, 0, '0);
        for (int i = 0; i < DW; i++) begin
            f = '0; f[i] = 1'b1;
            cyc(0, 0, 1, 0, f);
            idle();
        end
        idle();
        cyc(0, 0, 1, 0, 8'h01);
        cyc(0, 0, 0, 1, '0);
        idle();
        cyc(0, 0, 1, 0, 8'h10);
        cyc(0, 0, 0, 1, 8'h20);
        // Reset lands while in COMMIT
        cyc(0, 1, 0, 0, '0);
        cyc(0, 0, 1, 0, 8'b0000_1000);
        cyc(1, 0, 0, 0, '0);
        idle();
        cyc(0, 1, 0, 0, '0);

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: f = '0;
                1, 2: begin f = '0; f[$urandom_range(0, DW - 1)] = 1'b1; end
                default: f = DW'($urandom);
            endcase
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 5) == 0),
                f);
        end
        idle();

        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
